// File: rtl/xadc_drp_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : xadc_drp_master_if
//  Description : DRP bus plus end-of-conversion sideband between the XADC
//                wizard (slave side) and the DRP initiator (master side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface xadc_drp_master_if;
    logic [6:0]  daddr_out;
    logic        den_out;
    logic        dwe_out;
    logic [15:0] di_out;
    logic [15:0] do_in;
    logic        drdy_in;
    logic        eoc_in;
    logic [4:0]  channel_in;

    modport master (
        output daddr_out, den_out, dwe_out, di_out,
        input  do_in, drdy_in, eoc_in, channel_in
    );

    modport slave (
        input  daddr_out, den_out, dwe_out, di_out,
        output do_in, drdy_in, eoc_in, channel_in
    );
endinterface
`default_nettype wire

// File: rtl/xadc_drp_master.sv
`default_nettype none
// ============================================================================
//  Module      : xadc_drp_master
//  Description : Active DRP initiator for the XADC wizard. Writes a fixed
//                configuration sequence after reset, then reads the aux6 /
//                aux14 conversion results on each end-of-conversion and
//                publishes 12-bit samples with a one-cycle valid strobe.
//                Optional macro XADC_DRP_AVG_EN: publish the truncated mean
//                of every four reads per channel instead of each read.
//  Revision    : 1.0 - initial release
// ============================================================================
module xadc_drp_master #(
    parameter int         DRP_TIMEOUT = 64,
    parameter logic [6:0] ADDR_A      = 7'h16,
    parameter logic [6:0] ADDR_B      = 7'h1E
) (
    input  wire logic               CLK100MHZ,
    input  wire logic               reset,
    xadc_drp_master_if.master       drp,
    output logic [11:0]             sample_a,
    output logic [11:0]             sample_b,
    output logic                    sample_valid,
    output logic                    sample_ch,
    output logic                    cfg_done,
    output logic                    timeout_err
);

    localparam int                CNT_W    = (DRP_TIMEOUT > 1) ? $clog2(DRP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(DRP_TIMEOUT - 1);
    localparam logic [1:0]        CFG_LAST = 2'd3;

    typedef enum logic [2:0] {
        CFG_ISSUE = 3'd0,
        CFG_WAIT  = 3'd1,
        RUN_IDLE  = 3'd2,
        RD_ISSUE  = 3'd3,
        RD_WAIT   = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_cfg_idx, w_cfg_idx_nxt;
    logic [CNT_W-1:0]   r_tmo_cnt, w_tmo_cnt_nxt;
    logic               r_sel_b, w_sel_b_nxt;
    logic [6:0]         r_daddr, w_daddr_nxt;
    logic               r_den, w_den_nxt;
    logic               r_dwe, w_dwe_nxt;
    logic [15:0]        r_di, w_di_nxt;
    logic               r_cfg_done, w_cfg_done_nxt;
    logic               r_tmo_err, w_tmo_err_nxt;
    logic               w_rd_ok;

    logic [6:0]         w_rom_addr;
    logic [15:0]        w_rom_data;
    logic               w_hit_a, w_hit_b, w_tmo_hit;
    logic [11:0]        w_rd_data;

    logic [11:0]        r_sample_a, r_sample_b;
    logic               r_valid, r_ch;

    // Aux-channel status registers sit at the DRP address equal to the
    // channel number reported on channel_out, so the match is zero-extended.
    assign w_hit_a   = drp.eoc_in && ({2'b00, drp.channel_in} == ADDR_A);
    assign w_hit_b   = drp.eoc_in && ({2'b00, drp.channel_in} == ADDR_B);
    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
    assign w_rd_data = drp.do_in[15:4];

    // Configuration ROM: sequencer off, clock divider, aux enables, then
    // continuous sequencer mode last so conversions start fully configured.
    always_comb begin
        w_rom_addr = 7'h40;
        w_rom_data = 16'h0000;
        case (r_cfg_idx)
            2'd0: begin w_rom_addr = 7'h40; w_rom_data = 16'h0000; end
            2'd1: begin w_rom_addr = 7'h42; w_rom_data = 16'h0400; end
            2'd2: begin w_rom_addr = 7'h49; w_rom_data = 16'h4040; end
            default: begin w_rom_addr = 7'h41; w_rom_data = 16'h2F0F; end
        endcase
    end

    // State and DRP output registers; reset aborts any transaction in flight.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_state    <= CFG_ISSUE;
            r_cfg_idx  <= 2'd0;
            r_tmo_cnt  <= '0;
            r_sel_b    <= 1'b0;
            r_daddr    <= 7'h00;
            r_den      <= 1'b0;
            r_dwe      <= 1'b0;
            r_di       <= 16'h0000;
            r_cfg_done <= 1'b0;
            r_tmo_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cfg_idx  <= w_cfg_idx_nxt;
            r_tmo_cnt  <= w_tmo_cnt_nxt;
            r_sel_b    <= w_sel_b_nxt;
            r_daddr    <= w_daddr_nxt;
            r_den      <= w_den_nxt;
            r_dwe      <= w_dwe_nxt;
            r_di       <= w_di_nxt;
            r_cfg_done <= w_cfg_done_nxt;
            r_tmo_err  <= w_tmo_err_nxt;
        end
    end

    // Next-state and next-output logic; drdy is checked before the timeout
    // so a response on the last allowed cycle still completes cleanly.
    always_comb begin
        w_state_nxt    = r_state;
        w_cfg_idx_nxt  = r_cfg_idx;
        w_tmo_cnt_nxt  = r_tmo_cnt;
        w_sel_b_nxt    = r_sel_b;
        w_daddr_nxt    = r_daddr;
        w_den_nxt      = 1'b0;
        w_dwe_nxt      = 1'b0;
        w_di_nxt       = r_di;
        w_cfg_done_nxt = r_cfg_done;
        w_tmo_err_nxt  = r_tmo_err;
        w_rd_ok        = 1'b0;
        case (r_state)
            CFG_ISSUE: begin
                w_daddr_nxt   = w_rom_addr;
                w_di_nxt      = w_rom_data;
                w_den_nxt     = 1'b1;
                w_dwe_nxt     = 1'b1;
                w_tmo_cnt_nxt = '0;
                w_state_nxt   = CFG_WAIT;
            end
            CFG_WAIT: begin
                if (drp.drdy_in) begin
                    w_cfg_idx_nxt = r_cfg_idx + 2'd1;
                    if (r_cfg_idx == CFG_LAST) begin
                        w_cfg_done_nxt = 1'b1;
                        w_state_nxt    = RUN_IDLE;
                    end else begin
                        w_state_nxt    = CFG_ISSUE;
                    end
                end else if (w_tmo_hit) begin
                    w_tmo_err_nxt = 1'b1;
                    w_state_nxt   = CFG_ISSUE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                end
            end
            RUN_IDLE: begin
                if (w_hit_a) begin
                    w_sel_b_nxt = 1'b0;
                    w_state_nxt = RD_ISSUE;
                end else if (w_hit_b) begin
                    w_sel_b_nxt = 1'b1;
                    w_state_nxt = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                w_daddr_nxt   = r_sel_b ? ADDR_B : ADDR_A;
                w_di_nxt      = 16'h0000;
                w_den_nxt     = 1'b1;
                w_tmo_cnt_nxt = '0;
                w_state_nxt   = RD_WAIT;
            end
            RD_WAIT: begin
                if (drp.drdy_in) begin
                    w_rd_ok     = 1'b1;
                    w_state_nxt = RUN_IDLE;
                end else if (w_tmo_hit) begin
                    w_tmo_err_nxt = 1'b1;
                    w_state_nxt   = RUN_IDLE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = CFG_ISSUE;
            end
        endcase
    end

`ifdef XADC_DRP_AVG_EN
    logic [13:0] r_acc_a, r_acc_b, w_acc_sum;
    logic [1:0]  r_avg_cnt_a, r_avg_cnt_b, w_avg_cnt;

    assign w_acc_sum = (r_sel_b ? r_acc_b : r_acc_a) + {2'b00, w_rd_data};
    assign w_avg_cnt = r_sel_b ? r_avg_cnt_b : r_avg_cnt_a;

    // Accumulate four reads per channel, publish the truncated mean, restart.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_sample_a  <= 12'h000;
            r_sample_b  <= 12'h000;
            r_valid     <= 1'b0;
            r_ch        <= 1'b0;
            r_acc_a     <= 14'h0000;
            r_acc_b     <= 14'h0000;
            r_avg_cnt_a <= 2'd0;
            r_avg_cnt_b <= 2'd0;
        end else begin
            r_valid <= 1'b0;
            if (w_rd_ok) begin
                if (w_avg_cnt == 2'd3) begin
                    r_valid <= 1'b1;
                    r_ch    <= r_sel_b;
                    if (r_sel_b) begin
                        r_sample_b  <= w_acc_sum[13:2];
                        r_acc_b     <= 14'h0000;
                        r_avg_cnt_b <= 2'd0;
                    end else begin
                        r_sample_a  <= w_acc_sum[13:2];
                        r_acc_a     <= 14'h0000;
                        r_avg_cnt_a <= 2'd0;
                    end
                end else if (r_sel_b) begin
                    r_acc_b     <= w_acc_sum;
                    r_avg_cnt_b <= r_avg_cnt_b + 2'd1;
                end else begin
                    r_acc_a     <= w_acc_sum;
                    r_avg_cnt_a <= r_avg_cnt_a + 2'd1;
                end
            end
        end
    end
`else
    // Publish every successful read straight into its sample register.
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_sample_a <= 12'h000;
            r_sample_b <= 12'h000;
            r_valid    <= 1'b0;
            r_ch       <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_rd_ok) begin
                r_valid <= 1'b1;
                r_ch    <= r_sel_b;
                if (r_sel_b) begin
                    r_sample_b <= w_rd_data;
                end else begin
                    r_sample_a <= w_rd_data;
                end
            end
        end
    end
`endif

    assign drp.daddr_out = r_daddr;
    assign drp.den_out   = r_den;
    assign drp.dwe_out   = r_dwe;
    assign drp.di_out    = r_di;
    assign sample_a      = r_sample_a;
    assign sample_b      = r_sample_b;
    assign sample_valid  = r_valid;
    assign sample_ch     = r_ch;
    assign cfg_done      = r_cfg_done;
    assign timeout_err   = r_tmo_err;

endmodule
`default_nettype wire

// File: tb/tb_xadc_drp_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xadc_drp_master
//  Description : Self-checking bench for xadc_drp_master: DRP responder,
//                transaction and sample scoreboards, table-driven reads and
//                hand-written timeout / reset / overlap sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xadc_drp_master;

    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    xadc_drp_master_if drp ();
    logic [11:0] sample_a, sample_b;
    logic        sample_valid, sample_ch, cfg_done, timeout_err;

    xadc_drp_master #(.DRP_TIMEOUT(TMO), .ADDR_A(7'h16), .ADDR_B(7'h1E)) dut (
        .CLK100MHZ    (clk),
        .reset        (rst),
        .drp          (drp),
        .sample_a     (sample_a),
        .sample_b     (sample_b),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .cfg_done     (cfg_done),
        .timeout_err  (timeout_err)
    );

    typedef struct { logic [6:0] addr; logic [15:0] data; logic we; } txn_t;
    typedef struct { logic ch; logic [11:0] val; } smp_t;
    typedef struct { logic [4:0] ch; logic [15:0] data; bit rd; logic [11:0] exp_a; logic [11:0] exp_b; } vec_t;

    txn_t drp_q[$];
    smp_t smp_q[$];
    int   den_cyc_log[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int den_cnt = 0;
    int valid_cnt = 0;
    int exp_valid = 0;
    int resp_delay = 3;
    int drop_nth = 0;
    int pend = 0;
    int eoc_cyc = 0;
    int drdy_cyc = 0;
    int tmo_cyc = 0;
    bit tmo_seen = 0;
    bit stray_req = 0;
    logic [15:0] stray_data = 16'h0000;
    logic [15:0] rd_data = 16'h0000;

    logic [11:0] m_a, m_b;
    logic [13:0] m_acc [0:1];
    int          m_n   [0:1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    task automatic publish(input logic ch, input logic [11:0] v);
        smp_t s;
        s.ch = ch;
        s.val = v;
        smp_q.push_back(s);
        if (ch) m_b = v; else m_a = v;
        exp_valid++;
    endtask

    // Reference model of the publishing rule (direct or 4-read average).
    task automatic model_read(input logic ch, input logic [11:0] v);
`ifdef XADC_DRP_AVG_EN
        m_acc[ch] = m_acc[ch] + {2'b00, v};
        m_n[ch]++;
        if (m_n[ch] == 4) begin
            publish(ch, m_acc[ch][13:2]);
            m_acc[ch] = 14'h0;
            m_n[ch] = 0;
        end
`else
        publish(ch, v);
`endif
    endtask

    task automatic model_reset();
        m_a = 12'h0; m_b = 12'h0;
        m_acc[0] = 14'h0; m_acc[1] = 14'h0;
        m_n[0] = 0; m_n[1] = 0;
        smp_q.delete();
        drp_q.delete();
        den_cyc_log.delete();
        den_cnt = 0;
        tmo_seen = 0;
    endtask

    task automatic push_cfg(input int dup_idx);
        txn_t rom [4];
        rom[0] = '{7'h40, 16'h0000, 1'b1};
        rom[1] = '{7'h42, 16'h0400, 1'b1};
        rom[2] = '{7'h49, 16'h4040, 1'b1};
        rom[3] = '{7'h41, 16'h2F0F, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drp_q.push_back(rom[i]);
            if (i == dup_idx) drp_q.push_back(rom[i]);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_den",    {31'b0, drp.den_out}, 0);
        check("rst_dwe",    {31'b0, drp.dwe_out}, 0);
        check("rst_daddr",  {25'b0, drp.daddr_out}, 0);
        check("rst_di",     {16'b0, drp.di_out}, 0);
        check("rst_samp_a", {20'b0, sample_a}, 0);
        check("rst_samp_b", {20'b0, sample_b}, 0);
        check("rst_valid",  {31'b0, sample_valid}, 0);
        check("rst_ch",     {31'b0, sample_ch}, 0);
        check("rst_cfg",    {31'b0, cfg_done}, 0);
        check("rst_tmo",    {31'b0, timeout_err}, 0);
    endtask

    task automatic wait_cfg();
        int n;
        n = 0;
        while (cfg_done !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("cfg_done_rise", {31'b0, cfg_done}, 1);
    endtask

    // Assert reset away from both clock edges, verify outputs, reload the
    // expected configuration writes and release.
    task automatic reset_dut(input int dup_idx, input int drop);
        @(posedge clk);
        #2;
        rst = 1'b1;
        drp.eoc_in = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        drop_nth = drop;
        push_cfg(dup_idx);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        wait_cfg();
    endtask

    task automatic apply_eoc(input logic [4:0] ch, input logic [15:0] data, input bit expect_rd);
        txn_t t;
        rd_data = data;
        @(negedge clk);
        drp.channel_in = ch;
        drp.eoc_in = 1'b1;
        eoc_cyc = cyc;
        if (expect_rd) begin
            t.addr = {2'b00, ch};
            t.data = 16'h0000;
            t.we = 1'b0;
            drp_q.push_back(t);
            model_read(ch == 5'h1E, data[15:4]);
        end
        @(negedge clk);
        drp.eoc_in = 1'b0;
    endtask

    // DRP responder: checks each den against the expected-transaction queue
    // and answers with drdy resp_delay cycles later (or never, if dropped).
    initial begin
        txn_t t;
        drp.drdy_in = 1'b0;
        drp.do_in = 16'h0000;
        forever begin
            @(negedge clk);
            drp.drdy_in = 1'b0;
            if (rst) begin
                pend = 0;
            end else begin
                if (stray_req) begin
                    drp.drdy_in = 1'b1;
                    drp.do_in = stray_data;
                    stray_req = 0;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        drp.drdy_in = 1'b1;
                        drp.do_in = rd_data;
                        drdy_cyc = cyc;
                    end
                end
                if (drp.dwe_out === 1'b1 && drp.den_out !== 1'b1) fail_now("dwe_without_den");
                if (drp.den_out === 1'b1) begin
                    den_cnt++;
                    den_cyc_log.push_back(cyc);
                    if (drp_q.size() == 0) begin
                        fail_now("unexpected_den");
                    end else begin
                        t = drp_q.pop_front();
                        check("den_addr", {25'b0, drp.daddr_out}, {25'b0, t.addr});
                        check("den_we", {31'b0, drp.dwe_out}, {31'b0, t.we});
                        if (t.we) begin
                            check("cfg_data", {16'b0, drp.di_out}, {16'b0, t.data});
                            check("cfg_done_early", {31'b0, cfg_done}, 0);
                        end else begin
                            check("eoc_to_den", cyc - eoc_cyc, 2);
                        end
                    end
                    if (den_cnt != drop_nth) pend = resp_delay;
                end
            end
        end
    end

    // Sample monitor: pops the sample scoreboard on every valid strobe.
    initial begin
        smp_t s;
        forever begin
            @(negedge clk);
            if (!rst && sample_valid === 1'b1) begin
                valid_cnt++;
                check("drdy_to_valid", cyc - drdy_cyc, 1);
                if (smp_q.size() == 0) begin
                    fail_now("unexpected_valid");
                end else begin
                    s = smp_q.pop_front();
                    check("sample_ch", {31'b0, sample_ch}, {31'b0, s.ch});
                    check("sample_val", {20'b0, (s.ch ? sample_b : sample_a)}, {20'b0, s.val});
                end
            end
            if (!rst && timeout_err === 1'b1 && !tmo_seen) begin
                tmo_seen = 1;
                tmo_cyc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int d0, v0, e0;
        vecs[0] = '{5'h16, 16'hABC0, 1'b1, 12'hABC, 12'h000};
        vecs[1] = '{5'h1E, 16'hFFF0, 1'b1, 12'hABC, 12'hFFF};
        vecs[2] = '{5'h03, 16'h1230, 1'b0, 12'hABC, 12'hFFF};
        vecs[3] = '{5'h16, 16'h123F, 1'b1, 12'h123, 12'hFFF};
        vecs[4] = '{5'h1E, 16'h000F, 1'b1, 12'h123, 12'h000};
        vecs[5] = '{5'h06, 16'h5550, 1'b0, 12'h123, 12'h000};

        drp.eoc_in = 1'b0;
        drp.channel_in = 5'h00;

        // Power-up reset and clean configuration.
        reset_dut(-1, 0);
        check("cfg_writes", den_cnt, 4);
        check("cfg_tmo_clear", {31'b0, timeout_err}, 0);

        // Table-driven reads.
        for (int i = 0; i < 6; i++) begin
            d0 = den_cnt; v0 = valid_cnt; e0 = exp_valid;
            apply_eoc(vecs[i].ch, vecs[i].data, vecs[i].rd);
            repeat (10) @(negedge clk);
            check("vec_den", den_cnt - d0, {31'b0, vecs[i].rd});
            check("vec_valid", valid_cnt - v0, exp_valid - e0);
`ifdef XADC_DRP_AVG_EN
            check("vec_a", {20'b0, sample_a}, {20'b0, m_a});
            check("vec_b", {20'b0, sample_b}, {20'b0, m_b});
`else
            check("vec_a", {20'b0, sample_a}, {20'b0, vecs[i].exp_a});
            check("vec_b", {20'b0, sample_b}, {20'b0, vecs[i].exp_b});
`endif
        end

        // drdy outside a wait state must be ignored.
        v0 = valid_cnt;
        stray_data = 16'h7770;
        stray_req = 1;
        repeat (4) @(negedge clk);
        check("stray_valid", valid_cnt - v0, 0);
        check("stray_a", {20'b0, sample_a}, {20'b0, m_a});

        // Second eoc while a read is in flight is dropped.
        resp_delay = 8;
        d0 = den_cnt; v0 = valid_cnt; e0 = exp_valid;
        apply_eoc(5'h16, 16'h5A50, 1'b1);
        repeat (2) @(negedge clk);
        apply_eoc(5'h1E, 16'h5A50, 1'b0);
        repeat (15) @(negedge clk);
        check("ovl_den", den_cnt - d0, 1);
        check("ovl_valid", valid_cnt - v0, exp_valid - e0);
        check("ovl_b", {20'b0, sample_b}, {20'b0, m_b});

        // Reset while waiting for a read response; config restarts at 7'h40.
        resp_delay = 20;
        apply_eoc(5'h1E, 16'h1110, 1'b1);
        repeat (3) @(negedge clk);
        resp_delay = 3;
        reset_dut(-1, 0);
        check("rst_rd_writes", den_cnt, 4);

        // Second config write withheld: timeout, retry of 7'h42, completion.
        reset_dut(1, 2);
        check("tmo_writes", den_cnt, 5);
        check("tmo_sticky", {31'b0, timeout_err}, 1);
        if (den_cyc_log.size() >= 3) begin
            check("tmo_delay", tmo_cyc - den_cyc_log[1], TMO);
            check("tmo_retry", den_cyc_log[2] - den_cyc_log[1], TMO + 1);
        end else begin
            check("tmo_den_log", den_cyc_log.size(), 3);
        end
        drop_nth = 0;
        apply_eoc(5'h16, 16'h0420, 1'b1);
        repeat (10) @(negedge clk);
        check("tmo_sticky_run", {31'b0, timeout_err}, 1);
        check("tmo_read_a", {20'b0, sample_a}, {20'b0, m_a});

`ifdef XADC_DRP_AVG_EN
        // Four channel-A reads averaged into a single strobe.
        reset_dut(-1, 0);
        v0 = valid_cnt;
        apply_eoc(5'h16, 16'h1000, 1'b1); repeat (8) @(negedge clk);
        apply_eoc(5'h16, 16'h2000, 1'b1); repeat (8) @(negedge clk);
        apply_eoc(5'h16, 16'h3000, 1'b1); repeat (8) @(negedge clk);
        apply_eoc(5'h16, 16'h4010, 1'b1); repeat (8) @(negedge clk);
        check("avg_valid", valid_cnt - v0, 1);
        check("avg_a", {20'b0, sample_a}, 32'h280);
`endif

        check("drp_q_empty", drp_q.size(), 0);
        check("smp_q_empty", smp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
